rom_ram_copier: RTL and testbench

ROM_RAM_COPIER -- requirements
Module: rom_ram_copier

---
 rtl/rom_ram_copier_pkg.sv | 21 ++
 rtl/rom_ram_copier_rom.sv | 27 ++
 rtl/rom_ram_copier.sv | 134 +++++++++++++
 tb/tb_rom_ram_copier.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ram_copier_pkg.sv
// Shared types and constants for the ROM-to-RAM copier.
// rom_word() defines the ROM image; callers truncate to their word width.
package rom_ram_copier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DEPTH      = 16;

    // Result is (3*i+1); truncation to DATA_WIDTH bits gives the mod.
    function automatic int unsigned rom_word(input int unsigned i);
        return 3 * i + 1;
    endfunction

endpackage

// File: rtl/rom_ram_copier_rom.sv
// rom_image: synchronous-read ROM holding rom_word(addr).
// One cycle from i_addr to o_data.
module rom_image
    import rom_ram_copier_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_word;

    assign w_word = DATA_WIDTH'(rom_word(32'(i_addr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data <= '0;
        end else begin
            o_data <= w_word;
        end
    end

endmodule

// File: rtl/rom_ram_copier.sv
// Copies the rom_image contents into an inline RAM and serves host reads.
// Optional feature macro: COPY_CHECKSUM_EN (adds XOR checksum output).
module rom_ram_copier
    import rom_ram_copier_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
`ifdef COPY_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  rd_valid
);

    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] w_rom_data;
    logic [DATA_WIDTH-1:0] r_ram [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  w_rd_ok;
    logic                  w_oob;

    rom_image #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_addr (r_addr),
        .o_data (w_rom_data)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = COPY;
                end
            end
            COPY:    if (r_addr == LP_LAST) w_next = DRAIN;
            DRAIN:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign busy = (r_state == COPY) || (r_state == DRAIN);
    assign done = (r_state == DONE);

    // ROM data lags the issued address by one cycle, so delay the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= '0;
            end else if (r_state == COPY) begin
                r_addr <= r_addr + 1'b1;
            end
            r_wr_en   <= (r_state == COPY);
            r_wr_addr <= r_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (r_wr_en) begin
            r_ram[r_wr_addr] <= w_rom_data;
        end
    end

    assign w_rd_ok = rd_en && !busy;
    assign w_oob   = ({1'b0, rd_addr} >= LP_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data <= w_oob ? '0 : r_ram[rd_addr];
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

`ifdef COPY_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (r_wr_en) begin
            r_checksum <= r_checksum ^ w_rom_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_rom_ram_copier.sv
// Self-checking bench for rom_ram_copier: default build plus a wide instance.
// Define COPY_CHECKSUM_EN to also check the checksum output.
module tb_rom_ram_copier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic       rd_valid;

    logic       start2;
    logic       busy2;
    logic       done2;
    logic       rd_en2;
    logic [5:0] rd_addr2;
    logic [7:0] rd_data2;
    logic       rd_valid2;

`ifdef COPY_CHECKSUM_EN
    logic [3:0] checksum;
    logic [7:0] checksum2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_ram_copier dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
`ifdef COPY_CHECKSUM_EN
        .checksum (checksum),
`endif
        .rd_valid (rd_valid)
    );

    rom_ram_copier #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (6),
        .DEPTH      (40)
    ) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .busy     (busy2),
        .done     (done2),
        .rd_en    (rd_en2),
        .rd_addr  (rd_addr2),
        .rd_data  (rd_data2),
`ifdef COPY_CHECKSUM_EN
        .checksum (checksum2),
`endif
        .rd_valid (rd_valid2)
    );

    typedef struct {
        logic [3:0] addr;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_copy();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts busy cycles; disturb pokes a read and a second start mid-copy.
    task automatic wait_done(input bit disturb, input int exp_len);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (disturb) begin
                if (n == 3) begin
                    rd_en   = 1'b1;
                    rd_addr = 4'd3;
                end
                if (n == 4) begin
                    chk("rd_valid_while_busy", 32'(rd_valid), 0);
                    rd_en = 1'b0;
                end
                if (n == 6) start = 1'b1;
                if (n == 7) start = 1'b0;
            end
            tick();
        end
        chk("busy_len", n, exp_len);
        chk("done_after_copy", 32'(done), 1);
        chk("busy_after_copy", 32'(busy), 0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk("rd_valid", 32'(rd_valid), 1);
        chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(e));
    endtask

    initial begin
        logic [3:0] x;
        int n;

        tbl[0] = '{4'd0,  4'd1};
        tbl[1] = '{4'd5,  4'd0};
        tbl[2] = '{4'd15, 4'd14};
        tbl[3] = '{4'd3,  4'd10};
        tbl[4] = '{4'd10, 4'd15};
        tbl[5] = '{4'd7,  4'd6};

        rst_n    = 1'b0;
        start    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        start2   = 1'b0;
        rd_en2   = 1'b0;
        rd_addr2 = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
`ifdef COPY_CHECKSUM_EN
        chk("rst_checksum", 32'(checksum), 0);
`endif
        rst_n = 1'b1;
        tick();

        start_copy();
        chk("busy_after_start", 32'(busy), 1);
        wait_done(1'b1, 17);

        for (int i = 0; i < 6; i++) begin
            do_read(tbl[i].addr, tbl[i].exp);
        end
        tick();
        chk("rd_valid_idle", 32'(rd_valid), 0);
        chk("rd_data_hold", 32'(rd_data), 32'(tbl[5].exp));
        chk("done_holds", 32'(done), 1);

`ifdef COPY_CHECKSUM_EN
        x = '0;
        for (int i = 0; i < 16; i++) x = x ^ 4'(3 * i + 1);
        chk("checksum_done", 32'(checksum), 32'(x));
        start_copy();
        chk("checksum_cleared", 32'(checksum), 0);
        wait_done(1'b0, 17);
        chk("checksum_again", 32'(checksum), 32'(x));
`endif

        start_copy();
        repeat (7) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rd_valid", 32'(rd_valid), 0);
        chk("abort_rd_data", 32'(rd_data), 0);
`ifdef COPY_CHECKSUM_EN
        chk("abort_checksum", 32'(checksum), 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        start_copy();
        wait_done(1'b0, 17);
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 4'(3 * i + 1));
        end

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("busy2_len", n, 41);
        chk("done2", 32'(done2), 1);
        rd_en2   = 1'b1;
        rd_addr2 = 6'd39;
        tick();
        chk("rd2_valid_39", 32'(rd_valid2), 1);
        chk("rd2_data_39", 32'(rd_data2), 118);
        rd_addr2 = 6'd50;
        tick();
        rd_en2 = 1'b0;
        chk("rd2_valid_50", 32'(rd_valid2), 1);
        chk("rd2_data_50", 32'(rd_data2), 0);
        rd_en2   = 1'b1;
        rd_addr2 = 6'd20;
        tick();
        rd_en2 = 1'b0;
        chk("rd2_data_20", 32'(rd_data2), 61);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
